// File: rtl/demux_pkg.sv
// Shared types and helpers for the master-side demux front end.
package demux_pkg;

  localparam int unsigned SEL_W          = 2;
  localparam int unsigned NUM_DEST       = 3;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic {IDLE, HOLD} state_e;

  // First set bit of mask searching upward from last+1, wrapping; returns last if mask is empty.
  function automatic logic [SEL_W-1:0] rr_next(input logic [NUM_DEST-1:0] mask,
                                               input logic [SEL_W-1:0]    last);
    logic [SEL_W-1:0] res;
    logic             found;
    int unsigned      j;
    res   = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_DEST; i++) begin
      j = (32'(last) + i) % NUM_DEST;
      if (!found && mask[j]) begin
        res   = SEL_W'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_src_arbiter_rr_pick.sv
// Combinational round-robin picker: winner after last_i among eligible requesters.
module rr_pick
  import demux_pkg::*;
(
  input  logic [NUM_DEST-1:0] elig_i,
  input  logic [SEL_W-1:0]    last_i,
  output logic [SEL_W-1:0]    winner_o,
  output logic                any_o
);

  always_comb begin
    winner_o = rr_next(elig_i, last_i);
    any_o    = |elig_i;
  end

endmodule

// File: rtl/demux_src_arbiter.sv
// Round-robin arbiter feeding the shared 32-bit demux input; holds each word HOLD_CYCLES cycles.
module demux_src_arbiter
  import demux_pkg::*;
#(
  parameter int unsigned MST_DWIDTH  = 32,
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                          clk_mst,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*MST_DWIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            en_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [SEL_W-1:0]              select_o,
  output logic [MST_DWIDTH-1:0]         data_o,
  output logic                          valid_o,
  output logic                          busy_o
);

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [SEL_W-1:0]        last_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic [SEL_W-1:0]        sel_q;
  logic [MST_DWIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    busy_q;

  logic [NUM_REQ-1:0]      elig_d;
  logic [SEL_W-1:0]        win_d;
  logic                    any_d;
  logic [MST_DWIDTH-1:0]   words [NUM_REQ];

  assign elig_d = req_i & en_i;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign words[k] = req_data_i[k*MST_DWIDTH +: MST_DWIDTH];
  end

  rr_pick u_pick (
    .elig_i   (elig_d),
    .last_i   (last_q),
    .winner_o (win_d),
    .any_o    (any_d)
  );

  always_ff @(posedge clk_mst) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      ack_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (any_d) begin
            data_q       <= words[win_d];
            sel_q        <= win_d;
            valid_q      <= 1'b1;
            ack_q[win_d] <= 1'b1;
            last_q       <= win_d;
            cnt_q        <= HOLD_INIT;
            busy_q       <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  assign ack_o    = ack_q;
  assign select_o = sel_q;
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_demux_src_arbiter.sv
// Directed bench for demux_src_arbiter (HOLD_CYCLES=4 and HOLD_CYCLES=1 instances).
module tb_demux_src_arbiter;

  logic        clk_mst = 1'b0;
  logic        rst_n   = 1'b0;
  logic [2:0]  req     = '0;
  logic [2:0]  en      = 3'b111;
  logic [95:0] rdata   = '0;

  logic [2:0]  ack,   ack1;
  logic [1:0]  sel,   sel1;
  logic [31:0] data,  data1;
  logic        valid, valid1;
  logic        busy,  busy1;

  int checks = 0;
  int errors = 0;

  int g_cnt;
  int g_sel [8];
  int g_ack [8];
  int g_cyc [8];
  int saw1;

  always #5 clk_mst = ~clk_mst;

  demux_src_arbiter #(.MST_DWIDTH(32), .NUM_REQ(3), .HOLD_CYCLES(4)) dut (
    .clk_mst(clk_mst), .rst_n(rst_n), .req_i(req), .req_data_i(rdata), .en_i(en),
    .ack_o(ack), .select_o(sel), .data_o(data), .valid_o(valid), .busy_o(busy)
  );

  demux_src_arbiter #(.MST_DWIDTH(32), .NUM_REQ(3), .HOLD_CYCLES(1)) dut1 (
    .clk_mst(clk_mst), .rst_n(rst_n), .req_i(req), .req_data_i(rdata), .en_i(en),
    .ack_o(ack1), .select_o(sel1), .data_o(data1), .valid_o(valid1), .busy_o(busy1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_mst);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic collect(input int n);
    g_cnt = 0;
    saw1  = 0;
    for (int c = 0; c < 30 && g_cnt < n; c++) begin
      tick();
      if (ack[1] || sel == 2'd1) saw1 = 1;
      if (ack != 3'b000) begin
        g_sel[g_cnt] = int'(sel);
        g_ack[g_cnt] = int'(ack);
        g_cyc[g_cnt] = c;
        g_cnt++;
      end
    end
  endtask

  initial begin
    int exp_a [4];
    int exp_b [4];
    exp_a = '{0, 1, 2, 0};
    exp_b = '{0, 2, 0, 2};

    // Reset values
    tick();
    tick();
    check_eq("rst_ack",   ack,   0);
    check_eq("rst_sel",   sel,   0);
    check_eq("rst_data",  data,  0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy",  busy,  0);

    // Single word from source 0
    rdata[31:0] = 32'hA1B2C3D4;
    rst_n = 1'b1;
    req   = 3'b001;
    tick();
    check_eq("t1_ack",   ack,   3'b001);
    check_eq("t1_sel",   sel,   0);
    check_eq("t1_data",  data,  32'hA1B2C3D4);
    check_eq("t1_valid", valid, 1);
    check_eq("t1_busy",  busy,  1);
    req = 3'b000;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq("t1_hold_valid", valid, 1);
      check_eq("t1_hold_ack",   ack,   0);
    end
    tick();
    check_eq("t1_end_valid", valid, 0);
    check_eq("t1_end_busy",  busy,  0);
    check_eq("t1_end_data",  data,  32'hA1B2C3D4);

    // All sources requesting: 0,1,2,0, five cycles apart
    do_reset();
    rdata = {32'h22222222, 32'h11111111, 32'h00000000};
    en    = 3'b111;
    req   = 3'b111;
    collect(4);
    check_eq("t2_count", g_cnt, 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_sel", g_sel[k], exp_a[k]);
      check_eq("t2_ack", g_ack[k], 1 << exp_a[k]);
      if (k > 0) check_eq("t2_gap", g_cyc[k] - g_cyc[k-1], 5);
    end

    // Source 1 masked: 0,2,0,2
    do_reset();
    en  = 3'b101;
    req = 3'b111;
    collect(4);
    check_eq("t3_count", g_cnt, 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("t3_sel", g_sel[k], exp_b[k]);
      if (k > 0) check_eq("t3_gap", g_cyc[k] - g_cyc[k-1], 5);
    end
    check_eq("t3_no_src1", saw1, 0);

    // Word change during HOLD does not affect word in flight
    do_reset();
    en    = 3'b111;
    rdata = {32'h22222222, 32'h11111111, 32'h00000000};
    req   = 3'b110;
    tick();
    check_eq("t4_sel",  sel,  1);
    check_eq("t4_data", data, 32'h11111111);
    rdata[63:32] = 32'hDEADBEEF;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq("t4_hold_data", data, 32'h11111111);
    end
    tick();
    check_eq("t4_gap_valid", valid, 0);
    tick();
    check_eq("t4_next_sel",  sel,  2);
    check_eq("t4_next_ack",  ack,  3'b100);
    check_eq("t4_next_data", data, 32'h22222222);

    // Reset on second HOLD cycle aborts transfer
    do_reset();
    rdata = {32'h22222222, 32'h11111111, 32'h00000000};
    req   = 3'b001;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("t5_valid", valid, 0);
    check_eq("t5_data",  data,  0);
    check_eq("t5_sel",   sel,   0);
    check_eq("t5_busy",  busy,  0);
    check_eq("t5_ack",   ack,   0);
    rst_n = 1'b1;
    req   = 3'b110;
    tick();
    check_eq("t5_regrant_sel", sel, 1);
    check_eq("t5_regrant_ack", ack, 3'b010);

    // HOLD_CYCLES=1 instance: valid and ack alternate
    do_reset();
    req = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t6_valid", valid1, (i % 2 == 0) ? 1 : 0);
      check_eq("t6_ack",   ack1,   (i % 2 == 0) ? 3'b010 : 3'b000);
    end
    check_eq("t6_data", data1, 32'h11111111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_src_arbiter.md
Name: demux_src_arbiter

Overview:
- Round-robin arbiter and sequencer in front of the 3-way byte demux, in the clk_mst domain.
- Shares the single 32-bit master-side demux input between NUM_REQ word sources. Requester k always targets demux output k.
- Drives select/data/valid into the demux and holds each word stable for HOLD_CYCLES so the clk_sys side can serialise its 4 bytes.
- Returns a one-cycle ack to the winning source.

Parameters:
- MST_DWIDTH, 32, word width of each source and of data_o.
- NUM_REQ, 3, number of requesters, fixed at 3 to match the 2-bit demux select.
- HOLD_CYCLES, 4, clk_mst cycles valid_o stays high per word; legal range 1..15.

Ports:
- clk_mst  in  1  master clock.
- rst_n  in  1  synchronous, active-low reset on clk_mst.
- req_i  in  NUM_REQ  per-source request. Level signal, held until the source sees ack.
- req_data_i  in  NUM_REQ*MST_DWIDTH  source words. Source k occupies bits [k*MST_DWIDTH +: MST_DWIDTH].
- en_i  in  NUM_REQ  per-source enable mask. A masked source is never granted.
- ack_o  out  NUM_REQ  one-hot one-cycle pulse: word from source k captured.
- select_o  out  2  demux select. Equals the granted index; 2'b11 is never driven.
- data_o  out  MST_DWIDTH  word to the demux data_i.
- valid_o  out  1  to the demux valid_i.
- busy_o  out  1  high while in the HOLD state.

Behaviour:
- Reset (rst_n=0 at a clk_mst edge):
  - ack_o=0, select_o=0, data_o=0, valid_o=0, busy_o=0.
  - FSM goes to IDLE, hold counter=0, last_grant=NUM_REQ-1, so source 0 has first priority.
  - A reset asserted mid-transfer aborts the transfer immediately. No ack is re-issued.
- FSM states: IDLE, HOLD.
- IDLE:
  - Eligible set = req_i & en_i.
  - If the set is empty, stay in IDLE; all outputs hold and valid_o=0.
  - Otherwise the winner is the first eligible index searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - At the next edge:
    - data_o <= winner's word; select_o <= winner; valid_o <= 1.
    - ack_o[winner] <= 1; last_grant <= winner; counter <= HOLD_CYCLES-1; go to HOLD.
  - Latency from req_i seen in IDLE to valid_o/ack_o = 1 cycle.
- HOLD:
  - ack_o=0 from the second HOLD cycle on; ack is exactly one cycle wide.
  - valid_o, data_o and select_o stay stable. busy_o=1.
  - Counter decrements each cycle. When it reaches 0, at the next edge: valid_o <= 0, busy_o <= 0, go to IDLE.
  - valid_o is high for exactly HOLD_CYCLES cycles per word.
  - Minimum 1 cycle of valid_o=0 between words, so throughput is 1 word per HOLD_CYCLES+1 cycles.
- After a transfer, data_o and select_o keep their last values; only valid_o drops.
- Changes to req_i, en_i or req_data_i during HOLD do not affect the word in flight. They are evaluated only in IDLE.
- A source that drops req_i before its ack is simply not granted. There is no stored request.
- Source obligation: after ack_o[k], source k deasserts req_i[k] or presents its next word in the same cycle. Arbitration never re-samples a source during HOLD, so a held-high req_i[k] means "next word ready".
- Fairness:
  - With all three sources continuously requesting, the grant order is 0,1,2,0,1,...
  - A masked source is skipped without disturbing the pointer of the others.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package demux_pkg:
  - SEL_W=2, NUM_DEST=3, BYTES_PER_WORD=4.
  - State enum {IDLE, HOLD}.
  - Function rr_next(mask, last), returning the round-robin winner index.
- One natural sub-module: rr_pick, a combinational round-robin priority picker with inputs eligible vector and last_grant, and outputs winner index and any flag. The FSM, counter and output registers stay in demux_src_arbiter.

Test Plan:
- Reset then req_i=3'b001, word0=32'hA1B2C3D4, HOLD_CYCLES=4 -> after 1 cycle ack_o=3'b001 for 1 cycle; select_o=0, data_o=A1B2C3D4, valid_o=1 for exactly 4 cycles, then valid_o=0.
- req_i=3'b111 held with en_i=3'b111 -> grants 0,1,2,0; rising edges of valid_o 5 cycles apart; select_o sequence 0,1,2,0.
- req_i=3'b111, en_i=3'b101 -> grant sequence 0,2,0,2; ack_o[1] never asserts; select_o never equals 1.
- During HOLD of source 1, change req_data_i word1 to 32'hDEADBEEF -> data_o keeps the original word until valid_o falls; next grant goes to source 2.
- rst_n=0 on the 2nd HOLD cycle -> next edge valid_o=0, data_o=0, select_o=0, busy_o=0. After release with req_i=3'b110, source 1 is granted first.
- HOLD_CYCLES=1, req_i=3'b010 held -> valid_o pattern 1,0,1,0; ack_o[1] pulses every 2 cycles.
